sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//  Bridges the MEM-stage load/store unit to the board's external 256K x 16 asynchronous SRAM (IS61WV25616-class).
//  - Accepts one 32-bit byte-masked read or write per request over a ready/ack handshake.
//  - Splits each request into up to two 16-bit SRAM accesses and drives registered, glitch-free SRAM strobes.
//  - Sits directly downstream of the LSU data path; the top level exposes the SRAM pins from this block.
// PARAMETERS
//  WAIT_CYC  1  SRAM access cycles per half-word with we_n/oe_n asserted (>=1)
// PORTS
//  i_clk         in     1   clock, rising edge
//  i_rst         in     1   asynchronous, active-high reset
//  i_req         in     1   request valid; accepted when i_req && o_ready
//  i_wren        in     1   1 = write, 0 = read
//  i_addr        in     32  byte address; bits [18:2] used, others ignored
//  i_bmask       in     4   byte enables, bit n = byte n of the word
//  i_wdata       in     32  store data, byte lanes aligned to i_bmask
//  o_ready       out    1   block idle, may accept a request
//  o_ack         out    1   one-cycle pulse, request complete
//  o_rdata       out    32  load data, valid with o_ack, held until next accept
//  o_sram_addr   out    18  SRAM half-word address
//  io_sram_dq    inout  16  SRAM data bus
//  o_sram_ce_n   out    1   chip enable, active low
//  o_sram_we_n   out    1   write enable, active low
//  o_sram_oe_n   out    1   output enable, active low
//  o_sram_lb_n   out    1   lower byte enable, active low
//  o_sram_ub_n   out    1   upper byte enable, active low
// BEHAVIOUR
//  Reset values, applied immediately while i_rst=1:
//   o_ready=1, o_ack=0, o_rdata=0, o_sram_addr=0.
//   ce_n, we_n, oe_n, lb_n and ub_n all 1; dq tri-stated.
//  Accept:
//   - Inputs are latched on the accepting edge; o_ready drops the next cycle.
//   - i_req while o_ready=0 is ignored; the LSU must hold the request.
//  Half split:
//   - lo half = bytes 0-1, at addr {i_addr[18:2],0}; hi half = bytes 2-3, at addr {i_addr[18:2],1}.
//   - A half is accessed only if its two mask bits are not both 0.
//   - Order is lo then hi.
//  FSM: IDLE -> SETUP -> ACCESS(xWAIT_CYC) -> HOLD -> (next half ? SETUP : DONE) -> IDLE.
//   - SETUP: addr, ce_n=0, lb_n/ub_n = ~mask bits; write drives dq; we_n=oe_n=1.
//   - ACCESS: we_n=0 (write) or oe_n=0 (read); dq still driven on writes.
//   - HOLD: we_n=oe_n=1; addr, ce_n and dq held one cycle (write hold / read bus turnaround).
//   - DONE: ce_n=1, lb_n/ub_n=1, dq released, o_ack=1 for exactly one cycle.
//   - IDLE: o_ready=1.
//  Read capture:
//   - io_sram_dq is sampled on the edge ending the last ACCESS cycle, into o_rdata[15:0] (lo) or [31:16] (hi).
//   - A skipped half returns 0 in o_rdata.
//  Latency, accept edge to o_ack high:
//   - 2*(WAIT_CYC+2)+1 cycles for both halves (7 at default).
//   - WAIT_CYC+3 cycles for one half (4 at default).
//   - 1 cycle for i_bmask=0, with no SRAM strobes.
//  Back-to-back: the next accept is possible in the cycle after o_ack.
//  Bus safety: dq is driven only in SETUP/ACCESS/HOLD of a write, and never while oe_n=0.
//  Reset mid-operation: all strobes deassert asynchronously and dq is released. A partial write is not
//   completed and no o_ack is issued.
//  All SRAM outputs come straight from flops; no combinational path from i_* to SRAM pins.
// STRUCTURE
//  sram_ctrl_pkg:
//   - state enum typedef (IDLE, SETUP, ACCESS, HOLD, DONE).
//   - half-select typedef (LO/HI).
//   - localparams SRAM_AW=18, SRAM_DW=16.
//  Sub-module sram_io_pad: tri-state dq buffer (i_oe, i_dout[15:0], o_din[15:0], io_dq) with a registered
//   output enable.
//  Wait counter width: $clog2(WAIT_CYC+1).
// TESTING
//  1 Reset, then release -> o_ready=1, all *_n=1, dq=Z, o_ack=0.
//  2 Write addr 0x100, data 0xDEADBEEF, mask 1111:
//    - SRAM write to 0x080 with 0xBEEF, then to 0x081 with 0xDEAD, lb_n=ub_n=0.
//    - o_ack 7 cycles after accept.
//  3 Read addr 0x100, mask 1111 (behavioural SRAM model) -> o_rdata=0xDEADBEEF with o_ack; oe_n never low
//    while dq is driven.
//  4 Write addr 0x104, mask 0010, data 0x0000AB00:
//    - one access only, to 0x082 with lb_n=1, ub_n=0.
//    - o_ack after 4 cycles; byte 0 of the model unchanged.
//  5 Request with mask 0000 -> o_ack 1 cycle after accept, ce_n stays 1.
//    Second i_req pulsed while busy -> ignored, no extra ack.
//  6 Assert i_rst during ACCESS of a hi-half write -> strobes high and dq=Z the same cycle, no o_ack.
//    After release, o_ready=1 and a fresh read works.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared types and constants for the LSU-to-external-SRAM bridge.
//   - state_t : controller FSM states
//   - half_t  : which 16-bit half of the 32-bit word is being accessed
//   - SRAM_AW / SRAM_DW : external SRAM address / data widths
//   - half_used() : true when a half-word has at least one enabled byte
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_t;

  // A half is skipped entirely when both of its byte enables are clear.
  function automatic logic half_used(input logic [3:0] bmask, input half_t half);
    return (half == HALF_HI) ? (|bmask[3:2]) : (|bmask[1:0]);
  endfunction

endpackage

// File: rtl/sram_ctrl_io_pad.sv
// ---------------------------------------------------------------------------
// sram_io_pad
//   Tri-state buffer for the SRAM data bus. The output enable is registered
//   here so the bus turns on/off on a clock edge, aligned with the registered
//   strobes, and is released asynchronously by reset.
// Ports
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset (releases the bus)
//   i_oe    : next-cycle drive enable
//   i_dout  : data to drive (already registered by the caller)
//   o_din   : value currently seen on the bus
//   io_dq   : SRAM data bus
// ---------------------------------------------------------------------------
module sram_io_pad
  import sram_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_oe,
  input  logic [SRAM_DW-1:0] i_dout,
  output logic [SRAM_DW-1:0] o_din,
  inout  wire  [SRAM_DW-1:0] io_dq
);

  logic r_oe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oe <= 1'b0;
    end else begin
      r_oe <= i_oe;
    end
  end

  assign io_dq = r_oe ? i_dout : {SRAM_DW{1'bz}};
  assign o_din = io_dq;

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Bridges the MEM-stage load/store unit to a 256K x 16 asynchronous SRAM.
//   One 32-bit byte-masked request is split into up to two 16-bit accesses
//   (low half first), each walking SETUP -> ACCESS(xWAIT_CYC) -> HOLD.
//   Every SRAM pin is driven straight from a flop.
// Parameters
//   WAIT_CYC : cycles per half-word with we_n/oe_n asserted (>=1)
// Ports
//   i_clk, i_rst        : clock (rising edge), async active-high reset
//   i_req/o_ready       : request handshake, accepted when both high
//   i_wren              : 1 = write, 0 = read
//   i_addr              : byte address, bits [18:2] used
//   i_bmask             : byte enables, bit n = byte n
//   i_wdata             : store data
//   o_ack               : one-cycle completion pulse
//   o_rdata             : load data, valid with o_ack, held to next accept
//   o_sram_addr         : SRAM half-word address
//   io_sram_dq          : SRAM data bus
//   o_sram_ce_n/we_n/oe_n/lb_n/ub_n : active-low SRAM strobes
// ---------------------------------------------------------------------------
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = 1
)
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req,
  input  logic               i_wren,
  input  logic [31:0]        i_addr,
  input  logic [3:0]         i_bmask,
  input  logic [31:0]        i_wdata,
  output logic               o_ready,
  output logic               o_ack,
  output logic [31:0]        o_rdata,
  output logic [SRAM_AW-1:0] o_sram_addr,
  inout  wire  [SRAM_DW-1:0] io_sram_dq,
  output logic               o_sram_ce_n,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC - 1);

  // FSM and latched request
  state_t             r_state;
  half_t              r_half;
  logic [CW-1:0]      r_cnt;
  logic               r_wren;
  logic [3:0]         r_bmask;
  logic [16:0]        r_waddr;
  logic [31:0]        r_wdata;

  // Registered outputs
  logic               r_ready;
  logic               r_ack;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_dout;
  logic               r_ce_n;
  logic               r_we_n;
  logic               r_oe_n;
  logic               r_lb_n;
  logic               r_ub_n;

  // Next-state values
  logic               w_accept;
  state_t             w_state_nx;
  half_t              w_half_nx;
  logic [CW-1:0]      w_cnt_nx;
  logic               w_wren_nx;
  logic [3:0]         w_bmask_nx;
  logic [16:0]        w_waddr_nx;
  logic [31:0]        w_wdata_nx;
  logic               w_active_nx;
  logic               w_lb_en_nx;
  logic               w_ub_en_nx;
  logic               w_dq_oe_nx;
  logic [SRAM_DW-1:0] w_dout_nx;
  logic               w_capture;
  logic [SRAM_DW-1:0] w_din;
  logic               w_unused;

  assign w_accept = (r_state == ST_IDLE) && i_req;

  // On the accepting edge the fresh request feeds the output logic directly,
  // so the first SETUP cycle's strobes are already correct out of the flops.
  assign w_wren_nx  = w_accept ? i_wren       : r_wren;
  assign w_bmask_nx = w_accept ? i_bmask      : r_bmask;
  assign w_waddr_nx = w_accept ? i_addr[18:2] : r_waddr;
  assign w_wdata_nx = w_accept ? i_wdata      : r_wdata;

  // Request sequencing: pick the first used half, step through the access
  // phases, then either move to the high half or finish.
  always_comb begin
    w_state_nx = r_state;
    w_half_nx  = r_half;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (half_used(i_bmask, HALF_LO)) begin
            w_state_nx = ST_SETUP;
            w_half_nx  = HALF_LO;
          end else if (half_used(i_bmask, HALF_HI)) begin
            w_state_nx = ST_SETUP;
            w_half_nx  = HALF_HI;
          end else begin
            w_state_nx = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        w_state_nx = ST_ACCESS;
        w_cnt_nx   = '0;
      end
      ST_ACCESS: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nx = ST_HOLD;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        if ((r_half == HALF_LO) && half_used(r_bmask, HALF_HI)) begin
          w_state_nx = ST_SETUP;
          w_half_nx  = HALF_HI;
        end else begin
          w_state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Strobe values for the coming cycle, derived from the next state so the
  // pins can be registered without a cycle of lag.
  assign w_active_nx = (w_state_nx == ST_SETUP) || (w_state_nx == ST_ACCESS) ||
                       (w_state_nx == ST_HOLD);
  assign w_lb_en_nx  = (w_half_nx == HALF_HI) ? w_bmask_nx[2] : w_bmask_nx[0];
  assign w_ub_en_nx  = (w_half_nx == HALF_HI) ? w_bmask_nx[3] : w_bmask_nx[1];
  assign w_dq_oe_nx  = w_active_nx && w_wren_nx;
  assign w_dout_nx   = (w_half_nx == HALF_HI) ? w_wdata_nx[31:16] : w_wdata_nx[15:0];

  // Read data is taken on the edge that closes the final ACCESS cycle, while
  // oe_n is still low and the SRAM output has had the full access window.
  assign w_capture = (r_state == ST_ACCESS) && (r_cnt == CNT_LAST) && !r_wren;

  // Address bits outside the SRAM window are intentionally ignored.
  assign w_unused = &{1'b0, i_addr[31:19], i_addr[1:0]};

  // FSM, request latch and all registered outputs. Reset parks every strobe
  // high immediately, which also aborts any half-finished write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_half      <= HALF_LO;
      r_cnt       <= '0;
      r_wren      <= 1'b0;
      r_bmask     <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_ready     <= 1'b1;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dout      <= '0;
      r_ce_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_ub_n      <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_half  <= w_half_nx;
      r_cnt   <= w_cnt_nx;
      r_wren  <= w_wren_nx;
      r_bmask <= w_bmask_nx;
      r_waddr <= w_waddr_nx;
      r_wdata <= w_wdata_nx;

      r_ready <= (w_state_nx == ST_IDLE);
      r_ack   <= (w_state_nx == ST_DONE);

      r_ce_n <= ~w_active_nx;
      r_we_n <= ~((w_state_nx == ST_ACCESS) && w_wren_nx);
      r_oe_n <= ~((w_state_nx == ST_ACCESS) && !w_wren_nx);
      r_lb_n <= ~(w_active_nx && w_lb_en_nx);
      r_ub_n <= ~(w_active_nx && w_ub_en_nx);

      if (w_active_nx) begin
        r_sram_addr <= {w_waddr_nx, (w_half_nx == HALF_HI)};
        r_dout      <= w_dout_nx;
      end

      // Clearing on accept makes a skipped half read back as zero.
      if (w_accept) begin
        r_rdata <= '0;
      end else if (w_capture) begin
        if (r_half == HALF_HI) begin
          r_rdata[31:16] <= w_din;
        end else begin
          r_rdata[15:0] <= w_din;
        end
      end
    end
  end

  sram_io_pad u_pad (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_oe   (w_dq_oe_nx),
    .i_dout (r_dout),
    .o_din  (w_din),
    .io_dq  (io_sram_dq)
  );

  assign o_ready     = r_ready;
  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_sram_addr = r_sram_addr;
  assign o_sram_ce_n = r_ce_n;
  assign o_sram_we_n = r_we_n;
  assign o_sram_oe_n = r_oe_n;
  assign o_sram_lb_n = r_lb_n;
  assign o_sram_ub_n = r_ub_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//   Directed bench for sram_ctrl (WAIT_CYC = 1) with a behavioural async
//   SRAM on the pins and a weak probe driver used to show the data bus is
//   released when it should be.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam logic [15:0] PROBE = 16'h5A3C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  bmask = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic [17:0] sramAddr;
  wire  [15:0] sramDq;
  logic        sramCeN;
  logic        sramWeN;
  logic        sramOeN;
  logic        sramLbN;
  logic        sramUbN;

  logic        probeEn = 1'b0;
  logic [15:0] sramMem [0:262143];

  logic [17:0] wrAddrLog [$];
  logic [15:0] wrDataLog [$];
  logic [1:0]  wrLaneLog [$];

  int assertCount = 0;
  int failCount   = 0;
  int ackCount    = 0;
  int ceLowCount  = 0;
  int protoErrors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_CYC(1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_wren      (wren),
    .i_addr      (addr),
    .i_bmask     (bmask),
    .i_wdata     (wdata),
    .o_ready     (ready),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_sram_addr (sramAddr),
    .io_sram_dq  (sramDq),
    .o_sram_ce_n (sramCeN),
    .o_sram_we_n (sramWeN),
    .o_sram_oe_n (sramOeN),
    .o_sram_lb_n (sramLbN),
    .o_sram_ub_n (sramUbN)
  );

  // Behavioural SRAM: drives the bus while selected for read, stores on
  // each clock edge seen with we_n low, and logs every stored half-word.
  assign sramDq = (!sramCeN && !sramOeN && sramWeN) ? sramMem[sramAddr] : 16'hzzzz;
  assign sramDq = probeEn ? PROBE : 16'hzzzz;

  always @(posedge clk) begin
    if (!rst && !sramCeN && !sramWeN) begin
      if (!sramLbN) sramMem[sramAddr][7:0]  <= sramDq[7:0];
      if (!sramUbN) sramMem[sramAddr][15:8] <= sramDq[15:8];
      wrAddrLog.push_back(sramAddr);
      wrDataLog.push_back(sramDq);
      wrLaneLog.push_back({sramUbN, sramLbN});
    end
  end

  // Pin activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ack) ackCount++;
    if (!sramCeN) ceLowCount++;
    if (!sramOeN && !sramWeN) protoErrors++;
    if ((!sramOeN || !sramWeN) && sramCeN) protoErrors++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one request, returning accept-to-ack latency (-1 on timeout)
  // and the read data seen alongside o_ack.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] m,
                               input logic [31:0] d, output int latency,
                               output logic [31:0] rd);
    int  waitCnt;
    bit  got;
    @(negedge clk);
    waitCnt = 0;
    while (!ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    req = 1'b1; wren = w; addr = a; bmask = m; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    latency = -1;
    rd = '0;
    got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (ack) begin
        latency = n;
        rd = rdata;
        got = 1'b1;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    int          ackBefore;
    int          ceBefore;

    sramMem[18'h080] = 16'h0000;
    sramMem[18'h081] = 16'h0000;
    sramMem[18'h082] = 16'h1177;
    sramMem[18'h100] = 16'h0000;
    sramMem[18'h101] = 16'h1234;

    // 1: reset values, held and after release
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst_strobes", {27'd0, sramCeN, sramWeN, sramOeN, sramLbN, sramUbN}, 32'h1F);
    checkOutput("rst_addr", {14'd0, sramAddr}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    probeEn = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", {31'd0, ready}, 32'd1);
    checkOutput("idle_ack", {31'd0, ack}, 32'd0);
    checkOutput("idle_strobes", {27'd0, sramCeN, sramWeN, sramOeN, sramLbN, sramUbN}, 32'h1F);
    checkOutput("idle_dq_released", {16'd0, sramDq}, {16'd0, PROBE});
    probeEn = 1'b0;

    // 2: full-word write
    applyStimulus(1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, lat, rd);
    checkOutput("wr_full_latency", lat, 32'd7);
    checkOutput("wr_full_count", wrAddrLog.size(), 32'd2);
    if (wrAddrLog.size() == 2) begin
      checkOutput("wr_full_addr0", {14'd0, wrAddrLog[0]}, 32'h080);
      checkOutput("wr_full_data0", {16'd0, wrDataLog[0]}, 32'hBEEF);
      checkOutput("wr_full_lanes0", {30'd0, wrLaneLog[0]}, 32'd0);
      checkOutput("wr_full_addr1", {14'd0, wrAddrLog[1]}, 32'h081);
      checkOutput("wr_full_data1", {16'd0, wrDataLog[1]}, 32'hDEAD);
      checkOutput("wr_full_lanes1", {30'd0, wrLaneLog[1]}, 32'd0);
    end
    wrAddrLog.delete(); wrDataLog.delete(); wrLaneLog.delete();

    // 3: full-word read back, then a high-half-only read
    applyStimulus(1'b0, 32'h0000_0100, 4'b1111, 32'h0, lat, rd);
    checkOutput("rd_full_latency", lat, 32'd7);
    checkOutput("rd_full_data", rd, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0100, 4'b1100, 32'h0, lat, rd);
    checkOutput("rd_hi_latency", lat, 32'd4);
    checkOutput("rd_hi_data", rd, 32'hDEAD_0000);
    checkOutput("rd_no_writes", wrAddrLog.size(), 32'd0);

    // 4: single-byte write into upper byte of the low half
    applyStimulus(1'b1, 32'h0000_0104, 4'b0010, 32'h0000_AB00, lat, rd);
    checkOutput("wr_byte_latency", lat, 32'd4);
    checkOutput("wr_byte_count", wrAddrLog.size(), 32'd1);
    if (wrAddrLog.size() == 1) begin
      checkOutput("wr_byte_addr", {14'd0, wrAddrLog[0]}, 32'h082);
      checkOutput("wr_byte_lanes", {30'd0, wrLaneLog[0]}, 32'b01);
    end
    checkOutput("wr_byte_mem", {16'd0, sramMem[18'h082]}, 32'hAB77);
    wrAddrLog.delete(); wrDataLog.delete(); wrLaneLog.delete();

    // 5: empty mask, plus a request pulsed while busy
    @(negedge clk);
    ackBefore = ackCount;
    ceBefore  = ceLowCount;
    req = 1'b1; wren = 1'b0; addr = 32'h0000_0100; bmask = 4'b0000; wdata = '0;
    @(posedge clk);
    #1 wren = 1'b1; addr = 32'h0000_0300; bmask = 4'b1111; wdata = 32'h1111_2222;
    @(negedge clk);
    checkOutput("mask0_ack", {31'd0, ack}, 32'd1);
    checkOutput("mask0_busy", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1 req = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("mask0_ack_total", ackCount - ackBefore, 32'd1);
    checkOutput("mask0_ce_quiet", ceLowCount - ceBefore, 32'd0);
    checkOutput("busy_req_no_write", wrAddrLog.size(), 32'd0);

    // 6: reset during the high-half write access
    @(negedge clk);
    req = 1'b1; wren = 1'b1; addr = 32'h0000_0200; bmask = 4'b1111; wdata = 32'hCAFE_5678;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_in_hi_access", {13'd0, sramWeN, sramAddr}, {13'd0, 1'b0, 18'h101});
    ackBefore = ackCount;
    rst = 1'b1;
    probeEn = 1'b1;
    #1;
    checkOutput("abort_strobes", {27'd0, sramCeN, sramWeN, sramOeN, sramLbN, sramUbN}, 32'h1F);
    checkOutput("abort_dq_released", {16'd0, sramDq}, {16'd0, PROBE});
    checkOutput("abort_ack", {31'd0, ack}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    probeEn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_ready", {31'd0, ready}, 32'd1);
    checkOutput("abort_no_ack", ackCount - ackBefore, 32'd0);
    checkOutput("abort_lo_written", {16'd0, sramMem[18'h100]}, 32'h5678);
    checkOutput("abort_hi_untouched", {16'd0, sramMem[18'h101]}, 32'h1234);
    applyStimulus(1'b0, 32'h0000_0100, 4'b1111, 32'h0, lat, rd);
    checkOutput("post_rst_rd_latency", lat, 32'd7);
    checkOutput("post_rst_rd_data", rd, 32'hDEAD_BEEF);

    checkOutput("protocol_errors", protoErrors, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
